// File: rtl/demux_4way_reg_if.sv
// demux_4way_reg_if: write-side bus of the registered 1-to-4 demux.
//   slave  : used by demux_4way_reg (takes the write request, drives the held slots)
//   master : used by whoever issues the writes
// Signals:
//   CLEAR, IN_VALID, CONTROL[1:0], DATA_IN[WIDTH-1:0]   request side
//   IN_READY, OUT0..OUT3[WIDTH-1:0], STROBE[3:0], BUSY  response side
// Optional macro DEMUX_4WAY_AUTO_INC_EN adds AUTO (request) and PTR[1:0] (response).
interface demux_4way_reg_if #(
  parameter int WIDTH = 5
);
  logic             CLEAR;
  logic             IN_VALID;
  logic             IN_READY;
  logic [1:0]       CONTROL;
  logic [WIDTH-1:0] DATA_IN;
  logic [WIDTH-1:0] OUT0;
  logic [WIDTH-1:0] OUT1;
  logic [WIDTH-1:0] OUT2;
  logic [WIDTH-1:0] OUT3;
  logic [3:0]       STROBE;
  logic             BUSY;
`ifdef DEMUX_4WAY_AUTO_INC_EN
  logic             AUTO;
  logic [1:0]       PTR;

  modport slave  (input  CLEAR, IN_VALID, CONTROL, DATA_IN, AUTO,
                  output IN_READY, OUT0, OUT1, OUT2, OUT3, STROBE, BUSY, PTR);
  modport master (output CLEAR, IN_VALID, CONTROL, DATA_IN, AUTO,
                  input  IN_READY, OUT0, OUT1, OUT2, OUT3, STROBE, BUSY, PTR);
`else
  modport slave  (input  CLEAR, IN_VALID, CONTROL, DATA_IN,
                  output IN_READY, OUT0, OUT1, OUT2, OUT3, STROBE, BUSY);
  modport master (output CLEAR, IN_VALID, CONTROL, DATA_IN,
                  input  IN_READY, OUT0, OUT1, OUT2, OUT3, STROBE, BUSY);
`endif
endinterface

// File: rtl/demux_4way_reg.sv
// demux_4way_reg: registered 1-to-4 demultiplexer with optional write cooldown.
//   A write (IN_VALID & IN_READY) latches DATA_IN into slot CONTROL; the slot
//   shows it one cycle later with a one-cycle one-hot STROBE. After each write
//   the block can hold IN_READY low for HOLD_CYCLES cycles (BUSY high).
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous active-high reset
//   bus    demux_4way_reg_if.slave (request/response signals)
// Parameters: WIDTH, HOLD_CYCLES (0..15), RESET_VAL.
// Optional macro DEMUX_4WAY_AUTO_INC_EN: AUTO=1 routes writes to an internal
//   wrapping pointer PTR instead of CONTROL.
module demux_4way_reg #(
  parameter int               WIDTH       = 5,
  parameter int               HOLD_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  demux_4way_reg_if.slave       bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam bit       HAS_HOLD  = (HOLD_CYCLES != 0);
  // Counter starts at HOLD_CYCLES-1 so IN_READY is low for exactly HOLD_CYCLES cycles.
  localparam logic [3:0] HOLD_INIT = HAS_HOLD ? 4'(HOLD_CYCLES - 1) : 4'd0;

  state_t                    r_state, w_state_nxt;
  logic [3:0]                r_cnt, w_cnt_nxt;
  logic [3:0][WIDTH-1:0]     r_out;
  logic [3:0]                r_strobe;
  logic                      w_accept;
  logic [1:0]                w_sel;

  assign w_accept = bus.IN_VALID && (r_state == IDLE);

`ifdef DEMUX_4WAY_AUTO_INC_EN
  logic [1:0] r_ptr;

  assign w_sel   = bus.AUTO ? r_ptr : bus.CONTROL;
  assign bus.PTR = r_ptr;

  // Pointer survives CLEAR; only RESET brings it back to slot 0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                     r_ptr <= 2'd0;
    else if (w_accept && bus.AUTO) r_ptr <= r_ptr + 2'd1;
  end
`else
  assign w_sel = bus.CONTROL;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (w_accept && HAS_HOLD) begin
        w_state_nxt = HOLD;
        w_cnt_nxt   = HOLD_INIT;
      end
      HOLD: begin
        if (r_cnt == 4'd0) w_state_nxt = IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Slot registers: a write to a slot beats CLEAR for that slot only.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_out    <= {4{RESET_VAL}};
      r_strobe <= 4'd0;
    end else begin
      r_strobe <= w_accept ? (4'b0001 << w_sel) : 4'd0;
      for (int i = 0; i < 4; i++) begin
        if (w_accept && (w_sel == 2'(i))) r_out[i] <= bus.DATA_IN;
        else if (bus.CLEAR)               r_out[i] <= RESET_VAL;
      end
    end
  end

  assign bus.IN_READY = (r_state == IDLE);
  assign bus.BUSY     = (r_state == HOLD);
  assign bus.STROBE   = r_strobe;
  assign bus.OUT0     = r_out[0];
  assign bus.OUT1     = r_out[1];
  assign bus.OUT2     = r_out[2];
  assign bus.OUT3     = r_out[3];

endmodule
